// File: rtl/cmsdk_mcu_mtx4x2_output_arb_if.sv
// Output-stage arbiter bundle: request vector, granted-stage
// address-phase controls, and the registered grant result.
interface cmsdk_mcu_mtx4x2_output_arb_if;
  logic [3:0] req_port;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;

  modport master (
    output req_port,
    output HREADYM,
    output HSELM,
    output HTRANSM,
    output HBURSTM,
    output HMASTLOCKM,
    input  addr_in_port,
    input  no_port
  );

  modport slave (
    input  req_port,
    input  HREADYM,
    input  HSELM,
    input  HTRANSM,
    input  HBURSTM,
    input  HMASTLOCKM,
    output addr_in_port,
    output no_port
  );
endinterface

// File: rtl/cmsdk_mcu_mtx4x2_output_arb.sv
// Per-slave-port arbiter of the 4-input AHB matrix: picks the
// input stage owning the address phase, holding bursts and locks.
module cmsdk_mcu_mtx4x2_output_arb #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input logic HCLK,
  input logic HRESETn,
  cmsdk_mcu_mtx4x2_output_arb_if.slave bus
);

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_NSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ  = 2'b11;
  localparam logic [2:0] BU_INCR = 3'b001;

  logic [1:0] addr_q;
  logic [1:0] addr_d;
  logic [1:0] last_q;
  logic [1:0] last_d;
  logic       no_q;
  logic       no_d;
  logic [4:0] cnt_q;
  logic [4:0] cnt_d;
  logic [4:0] burst_len;
  logic       accept;
  logic       incr_run;
  logic       lock_hold;
  logic       busy_hold;
  logic       hold;
  logic       found;
  logic [1:0] winner;
  logic [1:0] base;
  logic [1:0] idx;

  assign accept = bus.HSELM & bus.HREADYM;

  // Beats remaining after the first, by burst length class
  always_comb begin
    burst_len = 5'd0;
    case (bus.HBURSTM[2:1])
      2'b00:   burst_len = 5'd0;
      2'b01:   burst_len = 5'd3;
      2'b10:   burst_len = 5'd7;
      default: burst_len = 5'd15;
    endcase
  end

  // Beat counter tracking the granted stage's fixed-length burst
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      case (bus.HTRANSM)
        TR_NSEQ: cnt_d = burst_len;
        TR_SEQ:  if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
        TR_IDLE: cnt_d = 5'd0;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Conditions that keep the current owner on the port
  always_comb begin
    incr_run  = accept
              & ((bus.HTRANSM == TR_NSEQ) | (bus.HTRANSM == TR_SEQ))
              & (bus.HBURSTM == BU_INCR)
              & bus.req_port[addr_q]
              & ~no_q;
    lock_hold = bus.HMASTLOCKM & bus.HSELM;
    busy_hold = (bus.HTRANSM == TR_BUSY) & (cnt_q != 5'd0);
    hold      = (cnt_d != 5'd0) | lock_hold | busy_hold | incr_run;
  end

  // Priority search: rotating after last winner, or fixed from 0
  always_comb begin
    found  = 1'b0;
    winner = 2'b00;
    idx    = 2'b00;
    base   = ROUND_ROBIN ? last_q + 2'd1 : 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && bus.req_port[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next grant: only re-arbitrate on a ready, unheld edge
  always_comb begin
    addr_d = addr_q;
    no_d   = no_q;
    last_d = last_q;
    if (bus.HREADYM && !hold) begin
      if (found) begin
        addr_d = winner;
        no_d   = 1'b0;
        last_d = winner;
      end else begin
        no_d   = 1'b1;
      end
    end
  end

  // Grant, pointer and beat-count registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= 2'b00;
      no_q   <= 1'b1;
      last_q <= 2'b11;
      cnt_q  <= 5'd0;
    end else begin
      addr_q <= addr_d;
      no_q   <= no_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.addr_in_port = addr_q;
  assign bus.no_port      = no_q;

endmodule
